// File: rtl/contador_ctrl_pkg.sv
// Shared definitions for the counter control stage.
//   state_t     : run-control FSM encoding (IDLE 00, RUN 01, PAUSE 10; 11 unused)
//   DB_MS       : default debounce time in milliseconds
//   SYNC_STAGES : depth of the per-button input synchroniser
package contador_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int DB_MS       = 10;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/contador_ctrl_btn_debounce.sv
// Per-button conditioning: 2-FF synchroniser, debounce counter, rising-edge detect.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   raw   in  raw active-high button, asynchronous to clk
//   press out one-cycle pulse for each accepted rising level
module btn_debounce
    import contador_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic                   stable;
    logic                   stable_d;
    logic [CW-1:0]          cnt;

    assign sync = sync_ff[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], raw};
            stable_d <= stable;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                // Level has differed for DB_CYCLES consecutive cycles: accept it.
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Releases update stable too, but only the rising level produces a pulse.
    assign press = stable & ~stable_d;

endmodule

// File: rtl/contador_ctrl.sv
// Run-control stage for the 0-99 counter: conditions three buttons and drives
// the counter's enable, clear and direction inputs.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_start_stop in   raw button: IDLE->RUN, RUN<->PAUSE
//   btn_clear      in   raw button: any state -> IDLE with a clear pulse
//   btn_dir        in   raw button: toggles count direction
//   count_en       out  1 while in RUN
//   count_clr      out  registered one-cycle clear pulse
//   count_up       out  1 = up, 0 = down
//   run_state      out  FSM state (00 IDLE, 01 RUN, 10 PAUSE)
module contador_ctrl
    import contador_ctrl_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DB_CYCLES = CLK_FREQ / 1000 * DB_MS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_dir,
    output logic       count_en,
    output logic       count_clr,
    output logic       count_up,
    output logic [1:0] run_state
);

    logic   ss_press;
    logic   clr_press;
    logic   dir_press;
    state_t state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_start_stop),
        .press (ss_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clear),
        .press (clr_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_dir),
        .press (dir_press)
    );

    assign run_state = state;

    // count_en is written alongside every state change so it always equals
    // (state == ST_RUN) without a combinational decode on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            count_up  <= 1'b1;
        end else begin
            count_clr <= clr_press;
            if (dir_press) begin
                count_up <= ~count_up;
            end

            // Clear has priority over a simultaneous start/stop press.
            if (clr_press) begin
                state    <= ST_IDLE;
                count_en <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_press) begin
                            state    <= ST_RUN;
                            count_en <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (ss_press) begin
                            state    <= ST_PAUSE;
                            count_en <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (ss_press) begin
                            state    <= ST_RUN;
                            count_en <= 1'b1;
                        end
                    end
                    default: begin
                        // Unused encoding 11 recovers to IDLE.
                        state    <= ST_IDLE;
                        count_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
